// File: rtl/cmd_pad_sequencer_if.sv
// rtl/cmd_pad_sequencer_if.sv - command/response handshake between the CMD pad sequencer and the card command decoder
interface cmd_pad_sequencer_if #(
   parameter int CMD_W       = 48,
   parameter int RESP_LONG_W = 136
);
   logic                   cmd_valid;
   logic [CMD_W-1:0]       cmd_frame;
   logic                   cmd_end_err;
   logic                   cmd_crc_err;
   logic                   resp_start;
   logic                   resp_long;
   logic [RESP_LONG_W-1:0] resp_frame;
   logic                   resp_skip;
   logic                   resp_done;
   logic                   resp_dropped;
   logic                   busy;

   modport master (
      output cmd_valid, cmd_frame, cmd_end_err, cmd_crc_err, resp_done, resp_dropped, busy,
      input  resp_start, resp_long, resp_frame, resp_skip
   );

   modport slave (
      input  cmd_valid, cmd_frame, cmd_end_err, cmd_crc_err, resp_done, resp_dropped, busy,
      output resp_start, resp_long, resp_frame, resp_skip
   );
endinterface

// File: rtl/cmd_pad_sequencer.sv
// rtl/cmd_pad_sequencer.sv - SD card CMD pad sequencer: command deserialiser and response serialiser
// Optional CRC7 checking of received commands is built when CMD_CRC7_CHECK_EN is defined.
module cmd_pad_sequencer #(
   parameter int CMD_W        = 48,
   parameter int RESP_SHORT_W = 48,
   parameter int RESP_LONG_W  = 136,
   parameter int NCR_CYCLES   = 2
) (
   input  logic                 clk_SD,
   input  logic                 rst_n_SD,
   input  logic                 data_out_serialToParallel,
   output logic                 data_in_parallelToSerial_PAD,
   output logic                 OutIn_control,
   output logic                 ENB_control,
   cmd_pad_sequencer_if.master  up
);
   typedef enum logic [2:0] {S_IDLE, S_RX, S_WAIT_RESP, S_NCR, S_TX, S_TX_END} state_t;

   state_t                 state_q, state_d;
   logic [CMD_W-2:0]       rx_sr;
   logic [7:0]             bit_cnt;
   logic [7:0]             ncr_cnt;
   logic [RESP_LONG_W-1:0] tx_sr;
   logic                   tx_long_q;
   logic [CMD_W-1:0]       cmd_frame_q;
   logic                   cmd_valid_q, end_err_q, dropped_q;
   logic                   rx_start, rx_done, resp_accept, dropped;
   logic                   sample;
   logic [7:0]             tx_last;

   assign sample  = data_out_serialToParallel;
   assign tx_last = tx_long_q ? 8'(RESP_LONG_W - 1) : 8'(RESP_SHORT_W - 1);

   always_ff @(posedge clk_SD or negedge rst_n_SD) begin
      if (!rst_n_SD) state_q <= S_IDLE;
      else           state_q <= state_d;
   end

   always_comb begin
      state_d     = state_q;
      rx_start    = 1'b0;
      rx_done     = 1'b0;
      resp_accept = 1'b0;
      dropped     = 1'b0;
      case (state_q)
         S_IDLE: if (!sample) begin
            state_d  = S_RX;
            rx_start = 1'b1;
         end
         S_RX: begin
            if (bit_cnt == 8'd1 && !sample) begin
               state_d = S_IDLE;
            end else if (bit_cnt == 8'(CMD_W - 1)) begin
               state_d = S_WAIT_RESP;
               rx_done = 1'b1;
            end
         end
         S_WAIT_RESP: begin
            if (up.resp_skip) begin
               state_d = S_IDLE;
            end else if (up.resp_start) begin
               state_d     = S_NCR;
               resp_accept = 1'b1;
            end else if (!sample) begin
               state_d  = S_RX;
               rx_start = 1'b1;
               dropped  = 1'b1;
            end
         end
         S_NCR:    if (ncr_cnt == 8'd0) state_d = S_TX;
         S_TX:     if (bit_cnt == tx_last) state_d = S_TX_END;
         S_TX_END: state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_SD or negedge rst_n_SD) begin
      if (!rst_n_SD) begin
         rx_sr         <= '0;
         bit_cnt       <= '0;
         ncr_cnt       <= '0;
         tx_sr         <= '0;
         tx_long_q     <= 1'b0;
         cmd_frame_q   <= '0;
         cmd_valid_q   <= 1'b0;
         end_err_q     <= 1'b0;
         dropped_q     <= 1'b0;
         OutIn_control <= 1'b0;
         ENB_control   <= 1'b0;
      end else begin
         ENB_control   <= 1'b1;
         // Enable trails the bit stream by one cycle to match the pad's output register.
         OutIn_control <= (state_q == S_TX);
         cmd_valid_q   <= rx_done;
         dropped_q     <= dropped;
         if (rx_start) begin
            rx_sr   <= {{(CMD_W-2){1'b0}}, sample};
            bit_cnt <= 8'd1;
         end else begin
            case (state_q)
               S_RX: begin
                  rx_sr   <= {rx_sr[CMD_W-3:0], sample};
                  bit_cnt <= bit_cnt + 8'd1;
               end
               S_NCR:   bit_cnt <= '0;
               S_TX:    bit_cnt <= bit_cnt + 8'd1;
               default: ;
            endcase
         end
         if (rx_done) begin
            cmd_frame_q <= {rx_sr, sample};
            end_err_q   <= ~sample;
         end
         if (resp_accept) begin
            tx_sr     <= up.resp_long ? up.resp_frame
                         : {up.resp_frame[RESP_SHORT_W-1:0], {(RESP_LONG_W-RESP_SHORT_W){1'b0}}};
            tx_long_q <= up.resp_long;
            ncr_cnt   <= 8'(NCR_CYCLES - 1);
         end else if (state_q == S_NCR) begin
            ncr_cnt <= ncr_cnt - 8'd1;
         end else if (state_q == S_TX) begin
            tx_sr <= {tx_sr[RESP_LONG_W-2:0], 1'b0};
         end
      end
   end

`ifdef CMD_CRC7_CHECK_EN
   logic [6:0] crc_q;
   logic       crc_err_q;

   function automatic logic [6:0] crc7_step(input logic [6:0] c, input logic b);
      logic fb;
      fb = c[6] ^ b;
      return {c[5:3], c[2] ^ fb, c[1:0], fb};
   endfunction

   // CRC covers frame bits 47..8, i.e. the first CMD_W-8 samples of the frame.
   always_ff @(posedge clk_SD or negedge rst_n_SD) begin
      if (!rst_n_SD) begin
         crc_q     <= '0;
         crc_err_q <= 1'b0;
      end else begin
         if (rx_start)
            crc_q <= crc7_step(7'd0, sample);
         else if (state_q == S_RX && bit_cnt < 8'(CMD_W - 8))
            crc_q <= crc7_step(crc_q, sample);
         if (rx_done)
            crc_err_q <= (crc_q != rx_sr[6:0]);
      end
   end

   assign up.cmd_crc_err = crc_err_q;
`else
   assign up.cmd_crc_err = 1'b0;
`endif

   assign data_in_parallelToSerial_PAD = (state_q == S_TX) ? tx_sr[RESP_LONG_W-1] : 1'b1;
   assign up.cmd_valid    = cmd_valid_q;
   assign up.cmd_frame    = cmd_frame_q;
   assign up.cmd_end_err  = end_err_q;
   assign up.resp_done    = (state_q == S_TX_END);
   assign up.resp_dropped = dropped_q;
   assign up.busy         = (state_q != S_IDLE);
endmodule

// File: tb/tb_cmd_pad_sequencer.sv
// tb/tb_cmd_pad_sequencer.sv - self-checking scoreboard bench for cmd_pad_sequencer
module tb_cmd_pad_sequencer;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n, din, pad_d, oe, enb;
   cmd_pad_sequencer_if ifc ();

   cmd_pad_sequencer dut (
      .clk_SD                       (clk),
      .rst_n_SD                     (rst_n),
      .data_out_serialToParallel    (din),
      .data_in_parallelToSerial_PAD (pad_d),
      .OutIn_control                (oe),
      .ENB_control                  (enb),
      .up                           (ifc.master)
   );

   typedef struct {
      logic [47:0] frame;
      logic        end_err;
      logic        crc_err;
   } cmd_exp_t;

   cmd_exp_t cmd_q[$];
   cmd_exp_t e_cur;
   logic     bit_q[$];
   int       len_q[$];
   int       n_chk = 0, n_pass = 0;
   int       done_cnt = 0, drop_cnt = 0, win_cnt = 0;
   logic     oe_prev = 1'b0;
   logic     pad_q = 1'b1;

   task automatic check(input string tag, input logic [135:0] got, input logic [135:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   function automatic logic [6:0] crc7_of(input logic [47:0] f);
      logic [6:0] c;
      logic       fb;
      c = '0;
      for (int i = 47; i >= 8; i--) begin
         fb = c[6] ^ f[i];
         c  = {c[5:0], 1'b0};
         if (fb) c = c ^ 7'h09;
      end
      return c;
   endfunction

   function automatic cmd_exp_t mk_exp(input logic [47:0] f);
      cmd_exp_t e;
      e.frame   = f;
      e.end_err = ~f[0];
`ifdef CMD_CRC7_CHECK_EN
      e.crc_err = (crc7_of(f) != f[7:1]);
`else
      e.crc_err = 1'b0;
`endif
      return e;
   endfunction

   function automatic logic [47:0] good_frame(input logic [5:0] idx, input logic [31:0] arg);
      logic [47:0] f;
      f      = {2'b01, idx, arg, 8'h01};
      f[7:1] = crc7_of(f);
      return f;
   endfunction

   // Pad output flip-flop: the line carries the previous cycle's serial bit.
   always @(posedge clk) pad_q <= pad_d;

   always @(negedge clk) begin
      if (rst_n) begin
         if (ifc.cmd_valid) begin
            if (cmd_q.size() == 0) check("unexpected_cmd_valid", 1, 0);
            else begin
               e_cur = cmd_q.pop_front();
               check("cmd_frame", ifc.cmd_frame, e_cur.frame);
               check("cmd_end_err", ifc.cmd_end_err, e_cur.end_err);
               check("cmd_crc_err", ifc.cmd_crc_err, e_cur.crc_err);
            end
         end
         if (oe) begin
            if (!oe_prev) win_cnt = 0;
            win_cnt++;
            if (bit_q.size() == 0) check("unexpected_tx_bit", 1, 0);
            else check("tx_bit", pad_q, bit_q.pop_front());
         end else if (oe_prev && len_q.size() > 0) begin
            check("tx_window_len", win_cnt, len_q.pop_front());
         end
         if (ifc.resp_done) done_cnt++;
         if (ifc.resp_dropped) drop_cnt++;
      end
      oe_prev = oe;
   end

   task automatic send_cmd(input logic [47:0] f);
      cmd_q.push_back(mk_exp(f));
      for (int i = 47; i >= 0; i--) begin
         din = f[i];
         @(negedge clk);
      end
      din = 1'b1;
   endtask

   task automatic start_resp(input logic lng, input logic [135:0] f);
      int n;
      n = lng ? 136 : 48;
      for (int i = 0; i < n; i++) bit_q.push_back(lng ? f[135-i] : f[47-i]);
      len_q.push_back(n);
      ifc.resp_long  = lng;
      ifc.resp_frame = f;
      ifc.resp_start = 1'b1;
      @(negedge clk);
      ifc.resp_start = 1'b0;
   endtask

   task automatic finish_resp(input logic loop0);
      if (loop0) din = 1'b0;
      for (int k = 0; k < 400 && !ifc.resp_done; k++) @(negedge clk);
      check("resp_done_seen", ifc.resp_done, 1);
      din = 1'b1;
      @(negedge clk);
      check("resp_done_pulse_width", ifc.resp_done, 0);
      check("busy_after_resp", ifc.busy, 0);
      @(negedge clk);
   endtask

   initial begin
      rst_n = 1'b0;
      din   = 1'b1;
      ifc.resp_start = 1'b0;
      ifc.resp_long  = 1'b0;
      ifc.resp_frame = '0;
      ifc.resp_skip  = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_pad_data", pad_d, 1);
      check("rst_oe", oe, 0);
      check("rst_enb", enb, 0);
      check("rst_busy", ifc.busy, 0);
      check("rst_cmd_frame", ifc.cmd_frame, 0);
      check("rst_cmd_valid", ifc.cmd_valid, 0);
      rst_n = 1'b1;
      @(negedge clk);
      check("enb_after_release", enb, 1);

      // CMD0, then end-bit error and bad-CRC frames, then random valid frames
      send_cmd(48'h400000000095);
      ifc.resp_skip = 1'b1; @(negedge clk); ifc.resp_skip = 1'b0;
      send_cmd(48'h400000000094);
      check("wait_resp_after_err", ifc.busy, 1);
      ifc.resp_skip = 1'b1; @(negedge clk); ifc.resp_skip = 1'b0;
      send_cmd(48'h400000000097);
      ifc.resp_skip = 1'b1; @(negedge clk); ifc.resp_skip = 1'b0;
      for (int r = 0; r < 2; r++) begin
         send_cmd(good_frame(6'($urandom_range(0, 63)), $urandom));
         ifc.resp_skip = 1'b1; @(negedge clk); ifc.resp_skip = 1'b0;
      end
      check("busy_after_skip", ifc.busy, 0);

      // short response, then long response with zeros looped back on the line
      send_cmd(good_frame(6'd17, 32'h0000_1000));
      start_resp(1'b0, 136'h01000001205F);
      finish_resp(1'b0);
      send_cmd(good_frame(6'd2, 32'h0));
      start_resp(1'b1, 136'h3F0123456789ABCDEFFEDCBA9876543210);
      finish_resp(1'b1);
      check("done_count_two", done_cnt, 2);

      // false start: transmission bit 0
      din = 1'b0;
      @(negedge clk);
      check("false_start_busy", ifc.busy, 1);
      @(negedge clk);
      check("false_start_idle", ifc.busy, 0);
      din = 1'b1;
      @(negedge clk);

      // resp_start ignored outside WAIT_RESP
      ifc.resp_start = 1'b1; @(negedge clk); ifc.resp_start = 1'b0;
      check("start_ignored_idle", ifc.busy, 0);

      // new command during WAIT_RESP drops the pending response
      send_cmd(good_frame(6'd8, 32'h0000_01AA));
      send_cmd(good_frame(6'd55, 32'h0));
      check("resp_dropped_count", drop_cnt, 1);

      // skip wins over start in the same cycle
      ifc.resp_skip = 1'b1; ifc.resp_start = 1'b1;
      @(negedge clk);
      ifc.resp_skip = 1'b0; ifc.resp_start = 1'b0;
      check("skip_priority_busy", ifc.busy, 0);
      repeat (6) @(negedge clk);
      check("skip_priority_no_tx", done_cnt, 2);

      // asynchronous reset in the middle of a transmission
      send_cmd(good_frame(6'd13, 32'h1234_0000));
      start_resp(1'b0, 136'h0D00000900A1);
      for (int k = 0; k < 20 && !oe; k++) @(negedge clk);
      check("tx_started", oe, 1);
      repeat (19) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_oe", oe, 0);
      check("async_rst_busy", ifc.busy, 0);
      check("async_rst_cmd_frame", ifc.cmd_frame, 0);
      check("async_rst_pad_data", pad_d, 1);
      bit_q.delete();
      len_q.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("enb_after_rerelease", enb, 1);
      send_cmd(good_frame(6'd7, 32'hABCD_0000));
      start_resp(1'b0, 136'h07000007004B);
      finish_resp(1'b0);

      check("done_count_final", done_cnt, 3);
      check("cmd_queue_drained", cmd_q.size(), 0);
      check("bit_queue_drained", bit_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
